draw_point_arbiter: RTL and testbench
=====================================

DRAW_POINT_ARBITER -- requirements
Module: draw_point_arbiter

Interface
REQ-001 SHALL have parameter BUF_W, default 320, frame buffer width in pixels.
REQ-002 SHALL have parameter BUF_H, default 240, frame buffer height in lines.
REQ-003 SHALL have parameter CLEAR_RGB, default 12'h000, RGB12 fill value for clear.
REQ-004 SHALL have ports (name, direction, width, meaning), clock and reset first:
- piul1Clock  in  1  single clock; all logic on rising edge.
- piul1Reset  in  1  synchronous, active-high reset.
- piul1CamReq  in  1  camera write request; held until ack.
- piul9CamPosX / piul9CamPosY  in  9 / 9  camera pixel coordinates.
- piul12CamRgb  in  12  camera pixel data.
- poul1CamAck  out  1  one-cycle pulse; camera request consumed.
- piul1OvlReq, piul9OvlPosX, piul9OvlPosY, piul12OvlRgb, poul1OvlAck  same as camera set, for the overlay requester.
- piul1ClearStart  in  1  pulse; start full-buffer clear.
- poul1ClearBusy  out  1  high while a clear sweep is in progress.
- poul9PosX / poul9PosY  out  9 / 9  write coordinates to the frame buffer write port.
- poul12Rgb  out  12  write data.
- poul1Update  out  1  write enable, one cycle per pixel.
- poul1OobError  out  1  one-cycle pulse; consumed request was out of range.

Function
REQ-005 SHALL implement states IDLE (arbitrate requesters) and CLEAR (fill sweep).
REQ-006 All outputs SHALL be registered. A request sampled at edge N SHALL produce ack, Update, coordinates and data in the cycle after edge N (latency 1).
REQ-007 A requester SHALL be eligible only when its Req is high and its Ack output is low. This prevents a held request from being consumed twice.
REQ-008 In IDLE, at most one requester SHALL be granted per cycle.
REQ-009 When both requesters are eligible, the one not granted last SHALL win (round-robin). When only one is eligible, it SHALL win.
REQ-010 The last-grant pointer SHALL update only on a grant.
REQ-011 For a grant with PosX < BUF_W and PosY < BUF_H:
- Update=1, with the grantee's coordinates and RGB;
- grantee Ack=1.
REQ-012 For a grant with PosX >= BUF_W or PosY >= BUF_H:
- grantee Ack=1 and OobError=1;
- Update=0; position and RGB outputs hold their previous values.
REQ-013 In any cycle with no write, Update SHALL be 0. Position and RGB outputs SHALL hold their previous values.
REQ-014 ClearStart sampled in IDLE SHALL enter CLEAR. It takes priority over any request sampled at the same edge; that request is neither granted nor acked.
REQ-015 ClearBusy SHALL rise in the same cycle as the first clear write.
REQ-016 The CLEAR sweep SHALL write CLEAR_RGB once per cycle in raster order:
- X from 0 to BUF_W-1, then wrap to 0 and increment Y;
- Y from 0 to BUF_H-1;
- total BUF_W*BUF_H consecutive Update cycles (76800 at defaults).
REQ-017 After the write at (BUF_W-1, BUF_H-1), the block SHALL return to IDLE. ClearBusy SHALL be 0 in the next cycle, and arbitration resumes at that edge.
REQ-018 During CLEAR, no Ack SHALL be asserted, requests SHALL remain pending, and ClearStart SHALL be ignored.
REQ-019 The clear X and Y counters SHALL be 9 bits wide and SHALL reset to 0 on entry to CLEAR.

Reset
REQ-020 While piul1Reset is high at an edge:
- all outputs SHALL be 0;
- state SHALL be IDLE and clear counters 0;
- the last-grant pointer SHALL equal overlay, so the camera wins the first tie.
REQ-021 Reset asserted mid-CLEAR SHALL abort the sweep. No Update SHALL occur in the cycle after the reset edge.
REQ-022 Requests held through reset SHALL be arbitrated normally from the first edge after reset deasserts.

Verification
REQ-023 Scenario, tie after reset: CamReq and OvlReq held high with distinct data. Required: Acks alternate Cam, Ovl, Cam, ...; Update=1 every cycle; the data written matches the acked requester.
REQ-024 Scenario, single requester: Cam only, (10,20), RGB 12'hABC, held. Required: Update and Ack in the next cycle with X=10, Y=20, RGB=ABC; then one Ack every 2 cycles.
REQ-025 Scenario, out of range: Ovl at (320,5) alone. Required: OvlAck=1 and OobError=1 one cycle later, Update=0. The same check with (0,240) gives the same response.
REQ-026 Scenario, clear: ClearStart pulse with CamReq held. Required: exactly 76800 Update cycles of 12'h000; first write at (0,0) and last at (319,239); no CamAck until the cycle after ClearBusy falls.
REQ-027 Scenario, simultaneous start: ClearStart and CamReq at the same edge. Required: no CamAck; the clear write to (0,0) occurs in the next cycle.
REQ-028 Scenario, reset mid-clear: Reset pulse at sweep pixel 1000. Required: all outputs 0 in the next cycle, ClearBusy=0, and no further clear writes.

Source files
------------

// File: rtl/draw_point_arbiter.sv
// Frame-buffer write-port arbiter: round-robin between camera and overlay
// pixel writers, plus a full-buffer clear sweep that preempts both.
module draw_point_arbiter #(
  parameter int unsigned BUF_W     = 320,
  parameter int unsigned BUF_H     = 240,
  parameter logic [11:0] CLEAR_RGB = 12'h000
) (
  input  logic        piul1Clock,
  input  logic        piul1Reset,
  input  logic        piul1CamReq,
  input  logic [8:0]  piul9CamPosX,
  input  logic [8:0]  piul9CamPosY,
  input  logic [11:0] piul12CamRgb,
  output logic        poul1CamAck,
  input  logic        piul1OvlReq,
  input  logic [8:0]  piul9OvlPosX,
  input  logic [8:0]  piul9OvlPosY,
  input  logic [11:0] piul12OvlRgb,
  output logic        poul1OvlAck,
  input  logic        piul1ClearStart,
  output logic        poul1ClearBusy,
  output logic [8:0]  poul9PosX,
  output logic [8:0]  poul9PosY,
  output logic [11:0] poul12Rgb,
  output logic        poul1Update,
  output logic        poul1OobError
);

  localparam int unsigned CW   = 9;
  localparam int unsigned CWE  = CW + 1;
  localparam int unsigned RGBW = 12;

  localparam logic [CW-1:0] X_LAST = CW'(BUF_W - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(BUF_H - 1);
  localparam logic [CWE-1:0] X_LIM = CWE'(BUF_W);
  localparam logic [CWE-1:0] Y_LIM = CWE'(BUF_H);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]   cnt_x, cnt_y, cnt_x_nxt, cnt_y_nxt;
  logic            last_ovl, last_ovl_nxt;
  logic            cam_ack_nxt, ovl_ack_nxt, update_nxt, oob_nxt, busy_nxt;
  logic [CW-1:0]   pos_x_nxt, pos_y_nxt;
  logic [RGBW-1:0] rgb_nxt;

  logic            sweep_last_c, start_clear_c, sweeping_c, arb_en_c;
  logic            cam_elig_c, ovl_elig_c, grant_cam_c, grant_ovl_c;
  logic [CW-1:0]   sel_x_c, sel_y_c;
  logic [RGBW-1:0] sel_rgb_c;
  logic            sel_in_range_c;
  logic [CW-1:0]   adv_x_c, adv_y_c;

  // Sweep control: the counters hold the pixel currently on the write port.
  assign sweep_last_c  = (cnt_x == X_LAST) && (cnt_y == Y_LAST);
  assign start_clear_c = (state == IDLE) && piul1ClearStart;
  assign sweeping_c    = (state == CLEAR) && !sweep_last_c;
  assign arb_en_c      = !start_clear_c && !sweeping_c;

  assign adv_x_c = (cnt_x == X_LAST) ? '0 : cnt_x + CW'(1);
  assign adv_y_c = (cnt_x == X_LAST) ? cnt_y + CW'(1) : cnt_y;

  // A requester whose ack is on the port this cycle must not be taken again.
  assign cam_elig_c  = piul1CamReq && !poul1CamAck;
  assign ovl_elig_c  = piul1OvlReq && !poul1OvlAck;
  assign grant_cam_c = arb_en_c && cam_elig_c && (!ovl_elig_c || last_ovl);
  assign grant_ovl_c = arb_en_c && ovl_elig_c && (!cam_elig_c || !last_ovl);

  assign sel_x_c   = grant_cam_c ? piul9CamPosX : piul9OvlPosX;
  assign sel_y_c   = grant_cam_c ? piul9CamPosY : piul9OvlPosY;
  assign sel_rgb_c = grant_cam_c ? piul12CamRgb : piul12OvlRgb;
  assign sel_in_range_c = ({1'b0, sel_x_c} < X_LIM) && ({1'b0, sel_y_c} < Y_LIM);

  // State and output registers.
  always_ff @(posedge piul1Clock) begin
    if (piul1Reset) begin
      state          <= IDLE;
      cnt_x          <= '0;
      cnt_y          <= '0;
      last_ovl       <= 1'b1;
      poul1CamAck    <= 1'b0;
      poul1OvlAck    <= 1'b0;
      poul1ClearBusy <= 1'b0;
      poul9PosX      <= '0;
      poul9PosY      <= '0;
      poul12Rgb      <= '0;
      poul1Update    <= 1'b0;
      poul1OobError  <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt_x          <= cnt_x_nxt;
      cnt_y          <= cnt_y_nxt;
      last_ovl       <= last_ovl_nxt;
      poul1CamAck    <= cam_ack_nxt;
      poul1OvlAck    <= ovl_ack_nxt;
      poul1ClearBusy <= busy_nxt;
      poul9PosX      <= pos_x_nxt;
      poul9PosY      <= pos_y_nxt;
      poul12Rgb      <= rgb_nxt;
      poul1Update    <= update_nxt;
      poul1OobError  <= oob_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (piul1ClearStart) state_nxt = CLEAR;
      CLEAR:   if (sweep_last_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath logic; the final sweep edge arbitrates like IDLE.
  always_comb begin
    cam_ack_nxt  = 1'b0;
    ovl_ack_nxt  = 1'b0;
    update_nxt   = 1'b0;
    oob_nxt      = 1'b0;
    busy_nxt     = 1'b0;
    pos_x_nxt    = poul9PosX;
    pos_y_nxt    = poul9PosY;
    rgb_nxt      = poul12Rgb;
    cnt_x_nxt    = cnt_x;
    cnt_y_nxt    = cnt_y;
    last_ovl_nxt = last_ovl;

    if (start_clear_c) begin
      cnt_x_nxt  = '0;
      cnt_y_nxt  = '0;
      update_nxt = 1'b1;
      busy_nxt   = 1'b1;
      pos_x_nxt  = '0;
      pos_y_nxt  = '0;
      rgb_nxt    = CLEAR_RGB;
    end else if (sweeping_c) begin
      cnt_x_nxt  = adv_x_c;
      cnt_y_nxt  = adv_y_c;
      update_nxt = 1'b1;
      busy_nxt   = 1'b1;
      pos_x_nxt  = adv_x_c;
      pos_y_nxt  = adv_y_c;
      rgb_nxt    = CLEAR_RGB;
    end else if (grant_cam_c || grant_ovl_c) begin
      cam_ack_nxt  = grant_cam_c;
      ovl_ack_nxt  = grant_ovl_c;
      last_ovl_nxt = grant_ovl_c;
      if (sel_in_range_c) begin
        update_nxt = 1'b1;
        pos_x_nxt  = sel_x_c;
        pos_y_nxt  = sel_y_c;
        rgb_nxt    = sel_rgb_c;
      end else begin
        oob_nxt = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_draw_point_arbiter.sv
// Self-checking bench for draw_point_arbiter: directed vector table, clear and
// reset-mid-clear sequences, and randomized traffic against a pixel-index model.
module tb_draw_point_arbiter;

  localparam int W = 320;
  localparam int H = 240;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic        cam_req, ovl_req;
  logic [8:0]  cam_x, cam_y, ovl_x, ovl_y;
  logic [11:0] cam_rgb, ovl_rgb;
  logic        cam_ack, ovl_ack, busy, update, oob;
  logic [8:0]  pos_x, pos_y;
  logic [11:0] rgb;

  int n_checks = 0;
  int n_errors = 0;

  draw_point_arbiter dut (
    .piul1Clock      (clk),
    .piul1Reset      (rst),
    .piul1CamReq     (cam_req),
    .piul9CamPosX    (cam_x),
    .piul9CamPosY    (cam_y),
    .piul12CamRgb    (cam_rgb),
    .poul1CamAck     (cam_ack),
    .piul1OvlReq     (ovl_req),
    .piul9OvlPosX    (ovl_x),
    .piul9OvlPosY    (ovl_y),
    .piul12OvlRgb    (ovl_rgb),
    .poul1OvlAck     (ovl_ack),
    .piul1ClearStart (clr),
    .poul1ClearBusy  (busy),
    .poul9PosX       (pos_x),
    .poul9PosY       (pos_y),
    .poul12Rgb       (rgb),
    .poul1Update     (update),
    .poul1OobError   (oob)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [34:0] pack(input logic b, u, ca, oa, ob,
                                       input logic [8:0] x, y, input logic [11:0] c);
    return {b, u, ca, oa, ob, x, y, c};
  endfunction

  wire [34:0] dut_vec = pack(busy, update, cam_ack, ovl_ack, oob, pos_x, pos_y, rgb);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: sweep tracked as a linear pixel index.
  logic        m_cam_ack = 0, m_ovl_ack = 0, m_update = 0, m_oob = 0, m_busy = 0;
  logic [8:0]  m_x = 0, m_y = 0;
  logic [11:0] m_rgb = 0;
  bit          m_clearing = 0;
  int          m_pix = 0;
  bit          m_last_ovl = 1;

  task automatic model_edge();
    bit ce, oe, gc;
    logic [8:0] px, py;
    if (rst) begin
      {m_cam_ack, m_ovl_ack, m_update, m_oob, m_busy} = '0;
      m_x = 0; m_y = 0; m_rgb = 0;
      m_clearing = 0; m_pix = 0; m_last_ovl = 1;
      return;
    end
    ce = cam_req && !m_cam_ack;
    oe = ovl_req && !m_ovl_ack;
    {m_cam_ack, m_ovl_ack, m_update, m_oob, m_busy} = '0;
    if (m_clearing && m_pix < W * H - 1) begin
      m_pix++;
      m_x = 9'(m_pix % W); m_y = 9'(m_pix / W); m_rgb = 12'h000;
      m_update = 1; m_busy = 1;
    end else if (!m_clearing && clr) begin
      m_clearing = 1; m_pix = 0;
      m_x = 0; m_y = 0; m_rgb = 12'h000;
      m_update = 1; m_busy = 1;
    end else begin
      m_clearing = 0;
      if (ce || oe) begin
        gc = ce && (!oe || m_last_ovl);
        m_last_ovl = !gc;
        px = gc ? cam_x : ovl_x;
        py = gc ? cam_y : ovl_y;
        if (gc) m_cam_ack = 1; else m_ovl_ack = 1;
        if (int'(px) < W && int'(py) < H) begin
          m_update = 1; m_x = px; m_y = py; m_rgb = gc ? cam_rgb : ovl_rgb;
        end else begin
          m_oob = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("outputs", 64'(dut_vec),
          64'(pack(m_busy, m_update, m_cam_ack, m_ovl_ack, m_oob, m_x, m_y, m_rgb)));
  endtask

  typedef struct {
    logic        rst;
    logic        cr;
    logic [8:0]  cx, cy;
    logic [11:0] crgb;
    logic        orq;
    logic [8:0]  ox, oy;
    logic [11:0] orgb;
    logic [34:0] exp;
  } vec_t;

  function automatic vec_t mkv(input logic r, input logic cr, input logic [8:0] cx, cy,
                               input logic [11:0] crgb, input logic orq,
                               input logic [8:0] ox, oy, input logic [11:0] orgb,
                               input logic [34:0] exp);
    vec_t v;
    v.rst = r; v.cr = cr; v.cx = cx; v.cy = cy; v.crgb = crgb;
    v.orq = orq; v.ox = ox; v.oy = oy; v.orgb = orgb; v.exp = exp;
    return v;
  endfunction

  vec_t tbl[21];

  initial begin
    logic [34:0] hold;
    int upd, guard;
    bit ack_during;
    logic [8:0] lx, ly;

    hold = pack(0, 0, 0, 0, 0, 9'd10, 9'd20, 12'hABC);
    tbl[0]  = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    tbl[1]  = mkv(0, 1, 9'd10, 9'd20, 12'hABC, 1, 9'd30, 9'd40, 12'h123, pack(0,1,1,0,0,9'd10,9'd20,12'hABC));
    tbl[2]  = mkv(0, 1, 9'd10, 9'd20, 12'hABC, 1, 9'd30, 9'd40, 12'h123, pack(0,1,0,1,0,9'd30,9'd40,12'h123));
    tbl[3]  = mkv(0, 1, 9'd10, 9'd20, 12'hABC, 1, 9'd30, 9'd40, 12'h123, pack(0,1,1,0,0,9'd10,9'd20,12'hABC));
    tbl[4]  = mkv(0, 1, 9'd10, 9'd20, 12'hABC, 1, 9'd30, 9'd40, 12'h123, pack(0,1,0,1,0,9'd30,9'd40,12'h123));
    tbl[5]  = mkv(0, 1, 9'd10, 9'd20, 12'hABC, 0, 0, 0, 0, pack(0,1,1,0,0,9'd10,9'd20,12'hABC));
    tbl[6]  = mkv(0, 1, 9'd10, 9'd20, 12'hABC, 0, 0, 0, 0, hold);
    tbl[7]  = mkv(0, 1, 9'd10, 9'd20, 12'hABC, 0, 0, 0, 0, pack(0,1,1,0,0,9'd10,9'd20,12'hABC));
    tbl[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, hold);
    tbl[9]  = mkv(0, 0, 0, 0, 0, 1, 9'd320, 9'd5, 12'h555, pack(0,0,0,1,1,9'd10,9'd20,12'hABC));
    tbl[10] = mkv(0, 0, 0, 0, 0, 1, 9'd320, 9'd5, 12'h555, hold);
    tbl[11] = mkv(0, 0, 0, 0, 0, 1, 9'd0, 9'd240, 12'h555, pack(0,0,0,1,1,9'd10,9'd20,12'hABC));
    tbl[12] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, hold);
    tbl[13] = mkv(0, 0, 0, 0, 0, 1, 9'd319, 9'd239, 12'hFFF, pack(0,1,0,1,0,9'd319,9'd239,12'hFFF));
    tbl[14] = mkv(0, 1, 9'd5, 9'd6, 12'h321, 0, 0, 0, 0, pack(0,1,1,0,0,9'd5,9'd6,12'h321));
    tbl[15] = mkv(1, 1, 9'd10, 9'd20, 12'hABC, 1, 9'd30, 9'd40, 12'h123, '0);
    tbl[16] = mkv(0, 1, 9'd10, 9'd20, 12'hABC, 1, 9'd30, 9'd40, 12'h123, pack(0,1,1,0,0,9'd10,9'd20,12'hABC));
    tbl[17] = mkv(0, 1, 9'd1, 9'd2, 12'h0F0, 1, 9'd511, 9'd0, 12'h777, pack(0,0,0,1,1,9'd10,9'd20,12'hABC));
    tbl[18] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, hold);
    tbl[19] = mkv(0, 1, 9'd319, 9'd240, 12'h444, 0, 0, 0, 0, pack(0,0,1,0,1,9'd10,9'd20,12'hABC));
    tbl[20] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, hold);

    rst = 1; clr = 0;
    cam_req = 0; cam_x = 0; cam_y = 0; cam_rgb = 0;
    ovl_req = 0; ovl_x = 0; ovl_y = 0; ovl_rgb = 0;

    // Directed vectors.
    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst;
      cam_req = tbl[i].cr; cam_x = tbl[i].cx; cam_y = tbl[i].cy; cam_rgb = tbl[i].crgb;
      ovl_req = tbl[i].orq; ovl_x = tbl[i].ox; ovl_y = tbl[i].oy; ovl_rgb = tbl[i].orgb;
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("vec%0d", i), 64'(dut_vec), 64'(tbl[i].exp));
    end

    // Full clear with camera request held, started at the same edge as the request.
    cam_req = 1; cam_x = 9'd7; cam_y = 9'd8; cam_rgb = 12'h9AB;
    ovl_req = 0; clr = 1;
    tick();
    check("clr_first", 64'({update, busy, cam_ack, pos_x, pos_y, rgb}),
          64'({1'b1, 1'b1, 1'b0, 9'd0, 9'd0, 12'h000}));
    upd = 1; guard = 0; ack_during = 0; lx = 0; ly = 0;
    while (busy && guard < 80000) begin
      clr = (guard == 500);
      tick();
      guard++;
      if (busy) begin
        if (update && rgb == 12'h000) upd++;
        if (cam_ack) ack_during = 1;
        lx = pos_x; ly = pos_y;
      end
    end
    clr = 0;
    check("clr_timeout", 64'(guard < 80000), 64'(1));
    check("clr_count", 64'(upd), 64'(76800));
    check("clr_last", 64'({lx, ly}), 64'({9'd319, 9'd239}));
    check("clr_no_ack", 64'(ack_during), 64'(0));
    check("ack_after_clr", 64'({cam_ack, update, pos_x, pos_y, rgb}),
          64'({1'b1, 1'b1, 9'd7, 9'd8, 12'h9AB}));
    cam_req = 0;
    tick();

    // Reset in the middle of a sweep.
    clr = 1;
    tick();
    clr = 0;
    for (int i = 0; i < 1000; i++) tick();
    check("pix1000", 64'({busy, update, pos_x, pos_y}), 64'({1'b1, 1'b1, 9'd40, 9'd3}));
    rst = 1;
    tick();
    check("rst_mid_clear", 64'(dut_vec), 64'(0));
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_write_after_rst", 64'({update, busy}), 64'(0));
    end

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      cam_req = ($urandom_range(0, 3) != 0);
      ovl_req = ($urandom_range(0, 2) != 0);
      cam_x = 9'($urandom_range(0, 330)); cam_y = 9'($urandom_range(0, 250));
      ovl_x = 9'($urandom_range(0, 330)); ovl_y = 9'($urandom_range(0, 250));
      cam_rgb = 12'($urandom); ovl_rgb = 12'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
